fifo_burst_arbiter: RTL

//  Shares the 16-slot synch_fifo write port (15 usable entries) among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_burst_arbiter_if.sv | 30 +++
 rtl/fifo_burst_arbiter_rr_pick.sv | 23 ++
 rtl/fifo_burst_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO burst arbiter slice.
package fifo_arb_pkg;

  localparam int unsigned FIFO_USABLE = 15;
  localparam int unsigned FIFO_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_burst_arbiter_if.sv
// Producer request / FIFO status bundle seen by the burst arbiter.
interface fifo_burst_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [FIFO_CNT_W-1:0]    fifo_avail;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     busy;
  logic                     stall;
  logic                     burst_done;

  modport master (
    input  req, req_len, fifo_avail, fifo_full,
    output fifo_wr_en, gnt, gnt_idx, busy, stall, burst_done
  );

  modport slave (
    output req, req_len, fifo_avail, fifo_full,
    input  fifo_wr_en, gnt, gnt_idx, busy, stall, burst_done
  );
endinterface

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after rr_ptr_i, modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_req_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    any_req_o = |req_i;
    win_idx_o = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      int k;
      k = (int'(rr_ptr_i) + i) % int'(NUM_REQ);
      if (req_i[k]) win_idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin arbiter granting whole bursts into the shared FIFO write port.
module fifo_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input logic                   clk,
  input logic                   rstn,
  fifo_burst_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = FIFO_CNT_W;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               stall_q, stall_d;
  logic               done_q, done_d;

  logic               any_req;
  logic [IDX_W-1:0]   win_idx;
  logic [LEN_W-1:0]   win_raw;
  logic [CNT_W-1:0]   win_len;
  logic [CNT_W-1:0]   issued;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .win_idx_o (win_idx)
  );

  // Effective burst length of the current round-robin winner.
  always_comb begin
    win_raw = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (IDX_W'(i) == win_idx) win_raw = bus.req_len[i*LEN_W +: LEN_W];
    end
    if (win_raw == '0)                            win_len = CNT_W'(1);
    else if (32'(win_raw) > 32'(MAX_BURST))       win_len = CNT_W'(MAX_BURST);
    else                                          win_len = CNT_W'(win_raw);
  end

  // Next-state logic; outputs are the registered view of the following cycle.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = gnt_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    issued     = beat_cnt_q + CNT_W'(wr_en_q);

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_idx_d  = win_idx;
          len_d      = win_len;
          beat_cnt_d = '0;
          if (win_len <= bus.fifo_avail) begin
            state_d = BURST;
            gnt_d   = onehot(win_idx);
            wr_en_d = !bus.fifo_full;
            done_d  = !bus.fifo_full && (win_len == CNT_W'(1));
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.req[gnt_idx_q]) begin
          state_d = IDLE;
        end else if (len_q <= bus.fifo_avail) begin
          state_d = BURST;
          gnt_d   = onehot(gnt_idx_q);
          wr_en_d = !bus.fifo_full;
          done_d  = !bus.fifo_full && (len_q == CNT_W'(1));
        end
      end
      BURST: begin
        // A full FIFO here means reserved space vanished; stall the beat rather than drop it.
        beat_cnt_d = issued;
        if (issued >= len_q) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        end else if (!bus.fifo_full) begin
          wr_en_d = 1'b1;
          done_d  = (issued == len_q - CNT_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d  = (state_d != IDLE);
    stall_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.busy       = busy_q;
  assign bus.stall      = stall_q;
  assign bus.burst_done = done_q;

endmodule
